// File: rtl/speles_pkg.sv
// rtl/speles_pkg.sv - shared types and constants for the round countdown timer
package speles_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int MAX_TIME        = 31;
  localparam int TICK_CYCLES_DEF = 50_000_000;

  // A zero start value would expire without ever counting, so it is promoted to one second.
  function automatic logic [4:0] load_value(input logic [4:0] v);
    return (v == 5'd0) ? 5'd1 : v;
  endfunction

endpackage

// File: rtl/laiks_bcd.sv
// rtl/laiks_bcd.sv - combinational 5-bit binary (0..31) to two BCD digits
module laiks_bcd (
  input  logic [4:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [4:0] w_sub;

  always_comb begin
    o_tens = 4'd0;
    w_sub  = 5'd0;
    if (i_bin >= 5'd30) begin
      o_tens = 4'd3;
      w_sub  = 5'd30;
    end else if (i_bin >= 5'd20) begin
      o_tens = 4'd2;
      w_sub  = 5'd20;
    end else if (i_bin >= 5'd10) begin
      o_tens = 4'd1;
      w_sub  = 5'd10;
    end
    o_ones = 4'(i_bin - w_sub);
  end

endmodule

// File: rtl/speles_taimeris.sv
// rtl/speles_taimeris.sv - round countdown timer: synchronizer, prescaler, FSM, BCD display
module speles_taimeris
  import speles_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_f,
  input  logic [4:0] time_v,
  output logic       end_f,
  output logic [4:0] remaining,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_fsd;
  logic [PW-1:0]   r_presc;
  logic [4:0]      r_remaining;
  logic            r_end_f;
  logic            r_running;

  logic            w_rise;
  logic            w_fall;
  logic            w_tick;

  assign w_rise = r_sync2 & ~r_fsd;
  assign w_fall = ~r_sync2 & r_fsd;
  assign w_tick = (r_presc == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_fsd       <= 1'b0;
      r_presc     <= '0;
      r_remaining <= 5'd0;
      r_end_f     <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_sync1 <= time_f;
      r_sync2 <= r_sync1;
      r_fsd   <= r_sync2;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_remaining <= load_value(time_v);
            r_presc     <= '0;
            r_running   <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          // An abort in a tick cycle suppresses the tick entirely.
          if (w_fall) begin
            r_running <= 1'b0;
            r_state   <= IDLE;
          end else if (w_tick) begin
            r_presc <= '0;
            if (r_remaining == 5'd1) begin
              r_remaining <= 5'd0;
              r_end_f     <= 1'b1;
              r_running   <= 1'b0;
              r_state     <= EXPIRED;
            end else begin
              r_remaining <= r_remaining - 5'd1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        EXPIRED: begin
          if (w_fall) begin
            r_end_f <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign remaining = r_remaining;
  assign end_f     = r_end_f;
  assign running   = r_running;

  laiks_bcd u_bcd (
    .i_bin  (r_remaining),
    .o_tens (tens),
    .o_ones (ones)
  );

endmodule
